// File: rtl/program_loader.sv
// Boot-time program loader: packs a big-endian byte stream into 32-bit words,
// writes them sequentially from address 0 and holds the CPU in reset until done.
module program_loader #(
   parameter int MEMORY_DEPTH = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [15:0] length_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        byte_ready_o,
   output logic        mem_write_o,
   output logic [31:0] mem_address_o,
   output logic [31:0] mem_data_o,
   output logic        cpu_hold_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        error_o
);

   localparam int IDX_W = $clog2(MEMORY_DEPTH + 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      DONE,
      ERROR
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  word_index;
   logic [1:0]        byte_count;
   logic [15:0]       length;
   logic [23:0]       partial;
   logic [15:0]       index_ext;
   logic              accept;
   logic              start_ok;

   assign index_ext = {{(16 - IDX_W){1'b0}}, word_index};
   assign accept    = (state == LOAD) && byte_valid_i;
   assign start_ok  = start_i && ((state == IDLE) || (state == DONE) || (state == ERROR));

   assign byte_ready_o = (state == LOAD);
   assign mem_write_o  = (state == WRITE);
   assign busy_o       = (state == LOAD) || (state == WRITE);
   assign cpu_hold_o   = (state != DONE);
   assign done_o       = (state == DONE);
   assign error_o      = (state == ERROR);

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERROR: begin
            if (start_i) begin
               if (length_i == 16'd0)
                  state_next = DONE;
               else if (length_i > 16'(MEMORY_DEPTH))
                  state_next = ERROR;
               else
                  state_next = LOAD;
            end
         end
         LOAD: begin
            if (accept && (byte_count == 2'd3))
               state_next = WRITE;
         end
         WRITE: begin
            if ((index_ext + 16'd1) == length)
               state_next = DONE;
            else
               state_next = LOAD;
         end
         default: state_next = IDLE;
      endcase
   end

   // The output word and address are captured with the 4th byte so they are
   // already stable for the single WRITE cycle and then simply hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         word_index    <= '0;
         byte_count    <= 2'd0;
         length        <= 16'd0;
         partial       <= 24'd0;
         mem_address_o <= 32'd0;
         mem_data_o    <= 32'd0;
      end else begin
         state <= state_next;
         if (start_ok) begin
            length     <= length_i;
            word_index <= '0;
            byte_count <= 2'd0;
         end
         if (accept) begin
            byte_count <= byte_count + 2'd1;
            case (byte_count)
               2'd0: partial[23:16] <= byte_i;
               2'd1: partial[15:8]  <= byte_i;
               2'd2: partial[7:0]   <= byte_i;
               default: begin
                  mem_data_o    <= {partial, byte_i};
                  mem_address_o <= {{(30 - IDX_W){1'b0}}, word_index, 2'b00};
               end
            endcase
         end
         if (state == WRITE)
            word_index <= word_index + 1'b1;
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: streams known programs,
// records every memory write and compares against hand-computed words.
module tb_program_loader;

   localparam int DEPTH = 32;

   logic        clk;
   logic        reset;
   logic        start_i;
   logic [15:0] length_i;
   logic        byte_valid_i;
   logic [7:0]  byte_i;
   logic        byte_ready_o;
   logic        mem_write_o;
   logic [31:0] mem_address_o;
   logic [31:0] mem_data_o;
   logic        cpu_hold_o;
   logic        busy_o;
   logic        done_o;
   logic        error_o;

   int          checkCount = 0;
   int          errorCount = 0;
   logic [31:0] prog [0:DEPTH-1];
   logic [31:0] wrAddr [$];
   logic [31:0] wrData [$];

   program_loader #(.MEMORY_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .length_i      (length_i),
      .byte_valid_i  (byte_valid_i),
      .byte_i        (byte_i),
      .byte_ready_o  (byte_ready_o),
      .mem_write_o   (mem_write_o),
      .mem_address_o (mem_address_o),
      .mem_data_o    (mem_data_o),
      .cpu_hold_o    (cpu_hold_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .error_o       (error_o)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every write strobe mid-cycle
   always @(negedge clk) begin
      if (mem_write_o) begin
         wrAddr.push_back(mem_address_o);
         wrData.push_back(mem_data_o);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseStart(input logic [15:0] len);
      start_i  = 1'b1;
      length_i = len;
      nextCycle();
      start_i  = 1'b0;
   endtask

   // Offer one byte after an optional gap and wait (bounded) for it to be taken
   task automatic sendByte(input logic [7:0] b, input int gap);
      bit taken = 1'b0;
      byte_valid_i = 1'b0;
      repeat (gap) nextCycle();
      byte_valid_i = 1'b1;
      byte_i       = b;
      for (int i = 0; i < 20 && !taken; i++) begin
         if (byte_ready_o) taken = 1'b1;
         nextCycle();
      end
      byte_valid_i = 1'b0;
      if (!taken) checkOutput("byte_accept_timeout", 32'd0, 32'd1);
   endtask

   // Stream prog[first..last]; returns in the WRITE cycle of the last word
   task automatic applyStimulus(input int first, input int last, input int maxGap);
      for (int w = first; w <= last; w++) begin
         for (int k = 0; k < 4; k++) begin
            logic [31:0] word;
            word = prog[w];
            sendByte(word[31-8*k -: 8], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
         end
         checkOutput($sformatf("wstrobe%0d", w), {31'd0, mem_write_o}, 32'd1);
         checkOutput($sformatf("wready%0d", w), {31'd0, byte_ready_o}, 32'd0);
      end
   endtask

   task automatic checkWrites(input string tag, input int n);
      checkOutput({tag, "_count"}, wrAddr.size(), n);
      for (int i = 0; i < n && i < wrAddr.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), wrAddr[i], 32'(i * 4));
         checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], prog[i]);
      end
      wrAddr.delete();
      wrData.delete();
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
      checkOutput({tag, "_wr"},    {31'd0, mem_write_o},  32'd0);
      checkOutput({tag, "_addr"},  mem_address_o,          32'd0);
      checkOutput({tag, "_data"},  mem_data_o,             32'd0);
      checkOutput({tag, "_hold"},  {31'd0, cpu_hold_o},   32'd1);
      checkOutput({tag, "_busy"},  {31'd0, busy_o},       32'd0);
      checkOutput({tag, "_done"},  {31'd0, done_o},       32'd0);
      checkOutput({tag, "_error"}, {31'd0, error_o},      32'd0);
   endtask

   initial begin
      reset        = 1'b0;
      start_i      = 1'b0;
      length_i     = 16'd0;
      byte_valid_i = 1'b0;
      byte_i       = 8'd0;
      #23;
      checkResetState("reset0");
      reset = 1'b1;
      nextCycle();

      // Two-word load, back-to-back bytes
      prog[0] = 32'h20080005;
      prog[1] = 32'h01095020;
      pulseStart(16'd2);
      checkOutput("load_ready", {31'd0, byte_ready_o}, 32'd1);
      checkOutput("load_busy",  {31'd0, busy_o},       32'd1);
      checkOutput("load_hold",  {31'd0, cpu_hold_o},   32'd1);
      applyStimulus(0, 1, 0);
      nextCycle();
      checkOutput("two_done", {31'd0, done_o},     32'd1);
      checkOutput("two_hold", {31'd0, cpu_hold_o}, 32'd0);
      checkOutput("two_busy", {31'd0, busy_o},     32'd0);
      checkWrites("two", 2);

      // Three words gapless, then the same words with random gaps
      prog[0] = 32'hDEADBEEF;
      prog[1] = 32'h00FF00FF;
      prog[2] = 32'h8C010004;
      pulseStart(16'd3);
      checkOutput("restart_hold", {31'd0, cpu_hold_o}, 32'd1);
      checkOutput("restart_done", {31'd0, done_o},     32'd0);
      applyStimulus(0, 2, 0);
      nextCycle();
      checkOutput("three_done", {31'd0, done_o}, 32'd1);
      checkWrites("three", 3);
      pulseStart(16'd3);
      applyStimulus(0, 2, 3);
      nextCycle();
      checkOutput("gap_done", {31'd0, done_o}, 32'd1);
      checkWrites("gap", 3);

      // Illegal length, with a stray byte offered while in ERROR
      pulseStart(16'(DEPTH + 1));
      checkOutput("ill_error", {31'd0, error_o},      32'd1);
      checkOutput("ill_ready", {31'd0, byte_ready_o}, 32'd0);
      checkOutput("ill_hold",  {31'd0, cpu_hold_o},   32'd1);
      checkOutput("ill_done",  {31'd0, done_o},       32'd0);
      byte_valid_i = 1'b1;
      byte_i       = 8'hAA;
      repeat (6) nextCycle();
      byte_valid_i = 1'b0;
      checkOutput("ill_stay", {31'd0, error_o}, 32'd1);
      checkOutput("ill_writes", wrAddr.size(), 0);
      // Upper bits of the length must not be ignored
      pulseStart(16'h0100);
      checkOutput("wide_error", {31'd0, error_o}, 32'd1);

      // Zero length from ERROR
      pulseStart(16'd0);
      checkOutput("zero_done",  {31'd0, done_o},  32'd1);
      checkOutput("zero_error", {31'd0, error_o}, 32'd0);
      checkOutput("zero_hold",  {31'd0, cpu_hold_o}, 32'd0);
      repeat (3) nextCycle();
      checkOutput("zero_writes", wrAddr.size(), 0);

      // Full depth, with an ignored start during LOAD
      for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA5000000 ^ (32'(i) * 32'h01010101);
      pulseStart(16'(DEPTH));
      applyStimulus(0, 2, 0);
      nextCycle();
      pulseStart(16'd5);
      checkOutput("stray_busy", {31'd0, busy_o}, 32'd1);
      applyStimulus(3, DEPTH - 1, 0);
      checkOutput("full_last_addr", mem_address_o, 32'((DEPTH - 1) * 4));
      nextCycle();
      checkOutput("full_done", {31'd0, done_o}, 32'd1);
      checkWrites("full", DEPTH);

      // Reset after two bytes of a word
      prog[0] = 32'h12345678;
      pulseStart(16'd2);
      sendByte(8'h11, 0);
      sendByte(8'h22, 0);
      reset = 1'b0;
      #1;
      checkResetState("midreset");
      nextCycle();
      reset = 1'b1;
      nextCycle();
      checkOutput("midreset_writes", wrAddr.size(), 0);
      pulseStart(16'd1);
      applyStimulus(0, 0, 1);
      nextCycle();
      checkOutput("reload_done", {31'd0, done_o}, 32'd1);
      checkWrites("reload", 1);

      // Start from DONE re-raises hold
      pulseStart(16'd1);
      checkOutput("redone_hold", {31'd0, cpu_hold_o}, 32'd1);
      checkOutput("redone_done", {31'd0, done_o},     32'd0);

      // Start coinciding with reset assertion is ignored
      start_i  = 1'b1;
      length_i = 16'd4;
      reset    = 1'b0;
      nextCycle();
      start_i = 1'b0;
      reset   = 1'b1;
      nextCycle();
      checkOutput("rststart_busy", {31'd0, busy_o}, 32'd0);
      checkOutput("rststart_hold", {31'd0, cpu_hold_o}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
